i2c_accel_target: RTL and testbench
===================================

// Module: i2c_accel_target
// PURPOSE
//  I2C target (slave) emulating an ADXL345 register map at 7-bit address DEV_ADDR.
//  Answers the FPGA-side I2C master on SCL/SDA, so the master can be brought up without the real sensor.
//  Holds a 64x8 register file; DATAX0..DATAZ1 (0x32-0x37) come from the live axis inputs.
//  Everything runs on CLOCK_50; SCL and SDA are oversampled, never used as clocks.
// PARAMETERS
//  DEV_ADDR    7'h53  7-bit target address (write byte 0xA6, read byte 0xA7)
//  DEVID_VAL   8'hE5  value returned at register 0x00
//  FILTER_LEN  4      glitch-filter stability window in CLOCK_50 cycles (used only with I2C_GLITCH_FILTER_EN)
// PORTS
//  CLOCK_50     in   1   system clock, 50 MHz
//  reset        in   1   synchronous, active-high
//  scl_in       in   1   raw SCL pin level
//  sda_in       in   1   raw SDA pin level
//  sda_oe       out  1   1 = pull SDA low; top level does assign SDAT = sda_oe ? 1'b0 : 1'bz
//  data_x       in   16  X sample -> 0x32 (low byte), 0x33 (high byte)
//  data_y       in   16  Y sample -> 0x34, 0x35
//  data_z       in   16  Z sample -> 0x36, 0x37
//  reg_wr       out  1   one-cycle pulse on each accepted write byte
//  reg_wr_addr  out  6   register written
//  reg_wr_data  out  8   byte written
//  busy         out  1   1 from an address match until STOP/START/reset
//  state_dbg    out  4   FSM state code, for a HEX display
// BEHAVIOUR
//  Reset values: sda_oe=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, busy=0, state=IDLE(0), pointer=0, regfile all 0x00.
//  Input path: 2-FF sync on SCL and SDA, then a previous-sample register for edge detection.
//  Bus events (on synced signals):
//   - START: SDA falls while SCL=1.
//   - STOP: SDA rises while SCL=1.
//   - SCL rise/fall: a one-cycle pulse on each edge.
//  Bit timing:
//   - Received bits are sampled on the SCL rise pulse.
//   - sda_oe changes only on the SCL fall pulse (within 1 cycle of it).
//  MSB first.
//  Byte counter: 3 bits; it wraps after the 8th bit, and the ACK slot is the 9th SCL pulse.
//  States (state_dbg code):
//   - IDLE(0): wait for START.
//   - ADDR(1): shift 8 bits. On match of {DEV_ADDR}, go to ADDR_ACK; on mismatch, go to IGNORE.
//   - ADDR_ACK(2): drive 0 for one bit. R=1 -> RDATA. R=0 -> REG.
//   - REG(3): shift 8 bits, set pointer = byte[5:0], then REG_ACK(4) -> WDATA.
//   - WDATA(5): shift 8 bits, then WDATA_ACK(6). In WDATA_ACK:
//     - write regfile[pointer] and pulse reg_wr;
//     - pointer += 1, wrapping 0x3F -> 0x00;
//     - ACK, then back to WDATA.
//   - RDATA(7): drive the byte; bit=0 -> sda_oe=1, bit=1 -> release. Then MACK(8) releases SDA and samples the master's ACK.
//     - ACK=0: pointer += 1 and go to RDATA.
//     - ACK=1 (NACK): go to IGNORE.
//   - IGNORE(9): SDA released; wait for STOP or START.
//  Read source:
//   - 0x00 -> DEVID_VAL.
//   - 0x32-0x37 -> snapshot of data_x/y/z, latched at the ADDR_ACK of a read, so a 6-byte burst is coherent.
//   - Others -> regfile.
//  Write protection: writes to 0x00 and 0x32-0x37 are ACKed but discarded (no reg_wr).
//  Priority: START (from any state, incl. mid-byte) -> ADDR with the bit counter cleared (repeated start).
//   STOP (any state) -> IDLE.
//   reset over both.
//  A partial byte at START/STOP is dropped: no write, no pointer change.
//  Reset mid-transfer releases SDA on the next edge and forces IDLE.
// CONFIGURATION
//  `define I2C_GLITCH_FILTER_EN:
//   - after the sync, SCL and SDA update only after FILTER_LEN consecutive equal samples;
//   - pulses shorter than FILTER_LEN cycles are ignored;
//   - event latency grows by FILTER_LEN cycles.
//  Undefined: no filter; latency is the 2-FF sync plus 1 cycle.
// TESTING
//  Bench model: 100 kHz open-drain master, pull-up modelled.
//  1. W 0xA6, 0x2C, 0x0B, STOP -> three ACKs; reg_wr pulse with addr=0x2C, data=0x0B; a later read of 0x2C returns 0x0B.
//  2. W 0xA6, 0x00, repeated START, 0xA7, read 1 byte, NACK, STOP -> 0xE5 on SDA; busy=0 after STOP.
//  3. data_x=0x1234, y=0xABCD, z=0x0F0E; read 6 bytes from 0x32 -> 34 12 CD AB 0E 0F.
//     Changing data_x mid-burst does not alter the bytes.
//  4. Address 0x3A (not a match) -> no ACK; sda_oe=0 for the whole transfer; state IGNORE until STOP.
//  5. STOP after 4 bits of WDATA -> IDLE, no reg_wr. Reset asserted mid-RDATA -> sda_oe=0, state_dbg=0 next cycle.
//  6. Built with I2C_GLITCH_FILTER_EN: a 2-cycle SCL low glitch during a byte -> no extra bit counted, byte still correct.

Source files
------------

// File: rtl/i2c_accel_target.sv
// I2C target emulating an ADXL345 register map (64x8 regfile, live DATAX0..DATAZ1).
// Optional `I2C_GLITCH_FILTER_EN adds a FILTER_LEN-cycle stability filter on SCL/SDA.
module i2c_accel_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h53,
  parameter logic [7:0]  DEVID_VAL  = 8'hE5,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  input  logic [15:0] data_z,
  output logic        reg_wr,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    MACK      = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  state_t      state, state_n;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_f, sda_f, scl_p, sda_p;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]  shift_r;
  logic [7:0]  rx_byte, rd_byte;
  logic [2:0]  bit_cnt;
  logic        rw, byte_done, oe_next, ptr_ro;
  logic [5:0]  pointer;
  logic [47:0] snap;
  logic [7:0]  regfile [64];

  // Bus lines reset high so releasing reset never looks like a START.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + CW'(1);
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + CW'(1);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_p;
  assign scl_fall  = ~scl_f & scl_p;
  assign start_det = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
  assign rx_byte   = {shift_r, sda_f};
  assign byte_done = scl_rise & (bit_cnt == 3'd7);
  assign ptr_ro    = (pointer == 6'h00) || (pointer >= 6'h32 && pointer <= 6'h37);

  always_comb begin
    rd_byte = regfile[pointer];
    case (pointer)
      6'h00:   rd_byte = DEVID_VAL;
      6'h32:   rd_byte = snap[7:0];
      6'h33:   rd_byte = snap[15:8];
      6'h34:   rd_byte = snap[23:16];
      6'h35:   rd_byte = snap[31:24];
      6'h36:   rd_byte = snap[39:32];
      6'h37:   rd_byte = snap[47:40];
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_det)     state_n = ADDR;
    else if (stop_det) state_n = IDLE;
    else if (scl_rise) begin
      case (state)
        ADDR:      if (byte_done) state_n = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_n = rw ? RDATA : REG;
        REG:       if (byte_done) state_n = REG_ACK;
        REG_ACK:   state_n = WDATA;
        WDATA:     if (byte_done) state_n = WDATA_ACK;
        WDATA_ACK: state_n = WDATA;
        RDATA:     if (byte_done) state_n = MACK;
        MACK:      state_n = sda_f ? IGNORE : RDATA;
        default:   ;
      endcase
    end
  end

  // Value sda_oe takes at the next SCL fall; ACK states pull low for the 9th bit.
  always_comb begin
    oe_next   = 1'b0;
    state_dbg = state;
    case (state)
      ADDR_ACK, REG_ACK, WDATA_ACK: oe_next = 1'b1;
      RDATA:   oe_next = ~rd_byte[3'd7 - bit_cnt];
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sda_oe      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
      shift_r     <= '0;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      pointer     <= '0;
      snap        <= '0;
      regfile     <= '{default: '0};
    end else begin
      reg_wr <= 1'b0;
      if (start_det || stop_det) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        if (scl_fall) sda_oe <= oe_next;
        if (scl_rise) begin
          case (state)
            ADDR, REG, WDATA, RDATA: begin
              shift_r <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
            end
            default: bit_cnt <= '0;
          endcase
        end
        if (byte_done) begin
          case (state)
            ADDR: begin
              rw <= rx_byte[0];
              if (rx_byte[7:1] == DEV_ADDR) busy <= 1'b1;
            end
            REG: pointer <= rx_byte[5:0];
            WDATA: begin
              if (!ptr_ro) begin
                regfile[pointer] <= rx_byte;
                reg_wr           <= 1'b1;
                reg_wr_addr      <= pointer;
                reg_wr_data      <= rx_byte;
              end
              pointer <= pointer + 6'd1;
            end
            default: ;
          endcase
        end
        if (scl_rise && state == ADDR_ACK && rw) snap <= {data_z, data_y, data_x};
        if (scl_rise && state == MACK && !sda_f) pointer <= pointer + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_accel_target.sv
// Bench for i2c_accel_target: open-drain master model with pull-up, scoreboard of expected bytes.
module tb_i2c_accel_target;
  localparam int Q = 300;  // quarter SCL period, scaled down to keep the run short

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic        sda_line;
  logic        sda_oe, reg_wr, busy;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic [3:0]  state_dbg;
  logic [15:0] data_x = '0, data_y = '0, data_z = '0;

  int          n_checks = 0, n_fail = 0;
  logic [15:0] sb_q[$];
  logic [13:0] exp_wr[$];
  logic [13:0] wr_log [256];
  int          wr_cnt = 0, wr_rd = 0, oe_cnt = 0;

  assign sda_line = ~(m_low | sda_oe);

  i2c_accel_target #(.DEV_ADDR(7'h53), .DEVID_VAL(8'hE5), .FILTER_LEN(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (reg_wr && wr_cnt < 256) begin
      wr_log[wr_cnt] = {reg_wr_addr, reg_wr_data};
      wr_cnt = wr_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [15:0] got);
    logic [15:0] exp;
    check({tag, "_sb_pending"}, 16'(sb_q.size() != 0), 16'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 16'(wr_cnt - wr_rd), 16'(exp_wr.size()));
    while (exp_wr.size() != 0) begin
      if (wr_rd < wr_cnt) begin
        check({tag, "_wr"}, 16'(wr_log[wr_rd]), 16'(exp_wr.pop_front()));
        wr_rd++;
      end else void'(exp_wr.pop_front());
    end
    wr_rd = wr_cnt;
  endtask

  task automatic clk_bit(input logic b, input logic g, output logic s);
    m_low = ~b;
    #(Q);
    scl = 1'b1;
    if (g) begin
      #40;
      scl = 1'b0;
      #40;
      scl = 1'b1;
      #(Q - 80);
    end else #(Q);
    s = sda_line;
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start;
    m_low = 1'b0;
    #(Q);
    scl = 1'b1;
    #(Q);
    m_low = 1'b1;
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    m_low = 1'b0;
    #(2 * Q);
  endtask

  task automatic write_byte_g(input logic [7:0] b, input logic exp_ack, input logic g);
    logic s;
    sb_q.push_back(16'(exp_ack));
    for (int i = 7; i >= 0; i--) clk_bit(b[i], g && (i == 4), s);
    clk_bit(1'b1, 1'b0, s);
    sb_check("ack", 16'(s));
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    write_byte_g(b, exp_ack, 1'b0);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, 1'b0, s);
  endtask

  task automatic read_reg(input logic [5:0] r, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte({2'b00, r}, 1'b0);
    i2c_start;
    write_byte(8'hA7, 1'b0);
    sb_q.push_back(16'(exp));
    read_byte(1'b1, d);
    sb_check(tag, 16'(d));
    i2c_stop;
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         oe0;

    repeat (5) @(posedge CLOCK_50);
    #1;
    check("rst_sda_oe", 16'(sda_oe), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_state", 16'(state_dbg), 16'd0);
    check("rst_reg_wr", 16'(reg_wr), 16'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    #(4 * Q);

    // write 0x0B to 0x2C, then read it back
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h2C, 1'b0);
    exp_wr.push_back({6'h2C, 8'h0B});
    write_byte(8'h0B, 1'b0);
    i2c_stop;
    check_writes("t1");
    read_reg(6'h2C, 8'h0B, "t1_readback");

    // protected registers: ACKed, never written
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h32, 1'b0);
    write_byte(8'h77, 1'b0);
    write_byte(8'h88, 1'b0);
    i2c_stop;
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h00, 1'b0);
    write_byte(8'h55, 1'b0);
    i2c_stop;
    check_writes("wprot");

    // DEVID through a repeated START
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h00, 1'b0);
    i2c_start;
    write_byte(8'hA7, 1'b0);
    check("t2_busy", 16'(busy), 16'd1);
    sb_q.push_back(16'hE5);
    read_byte(1'b1, d);
    sb_check("t2_devid", 16'(d));
    i2c_stop;
    check("t2_busy_after_stop", 16'(busy), 16'd0);
    check("t2_state_idle", 16'(state_dbg), 16'd0);

    // coherent 6-byte axis burst
    data_x = 16'h1234;
    data_y = 16'hABCD;
    data_z = 16'h0F0E;
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h32, 1'b0);
    i2c_start;
    write_byte(8'hA7, 1'b0);
    foreach (d[i]) ;
    sb_q.push_back(16'h34); sb_q.push_back(16'h12); sb_q.push_back(16'hCD);
    sb_q.push_back(16'hAB); sb_q.push_back(16'h0E); sb_q.push_back(16'h0F);
    for (int i = 0; i < 6; i++) begin
      read_byte(i == 5, d);
      sb_check("t3_axis", 16'(d));
      if (i == 1) data_x = 16'hFFFF;
    end
    i2c_stop;

    // non-matching address 0x3A
    oe0 = oe_cnt;
    i2c_start;
    write_byte(8'h74, 1'b1);
    check("t4_ignore", 16'(state_dbg), 16'd9);
    write_byte(8'h55, 1'b1);
    check("t4_ignore2", 16'(state_dbg), 16'd9);
    i2c_stop;
    check("t4_no_drive", 16'(oe_cnt - oe0), 16'd0);
    check("t4_idle", 16'(state_dbg), 16'd0);
    check_writes("t4");

    // auto-increment write, then a partial byte that must be dropped
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h10, 1'b0);
    exp_wr.push_back({6'h10, 8'h5A});
    write_byte(8'h5A, 1'b0);
    exp_wr.push_back({6'h11, 8'h6B});
    write_byte(8'h6B, 1'b0);
    i2c_stop;
    check_writes("t5_burst");
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h10, 1'b0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, s);
    i2c_stop;
    check("t5_partial_idle", 16'(state_dbg), 16'd0);
    check_writes("t5_partial");
    i2c_start;
    write_byte(8'hA7, 1'b0);
    sb_q.push_back(16'h5A);
    sb_q.push_back(16'h6B);
    read_byte(1'b0, d);
    sb_check("t5_rd0", 16'(d));
    read_byte(1'b1, d);
    sb_check("t5_rd1", 16'(d));
    i2c_stop;

    // reset while the target is driving a 0 data bit (0x2C = 0x0B, MSB 0)
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h2C, 1'b0);
    i2c_start;
    write_byte(8'hA7, 1'b0);
    m_low = 1'b0;
    #(Q);
    scl = 1'b1;
    #(Q);
    check("t5_rdata_drive", 16'(sda_oe), 16'd1);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("t5_rst_sda_oe", 16'(sda_oe), 16'd0);
    check("t5_rst_state", 16'(state_dbg), 16'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    scl = 1'b0;
    #(Q);
    i2c_stop;
    read_reg(6'h2C, 8'h00, "t5_regfile_cleared");

`ifdef I2C_GLITCH_FILTER_EN
    i2c_start;
    write_byte(8'hA6, 1'b0);
    write_byte(8'h20, 1'b0);
    exp_wr.push_back({6'h20, 8'hC3});
    write_byte_g(8'hC3, 1'b0, 1'b1);
    i2c_stop;
    check_writes("t6_glitch");
    read_reg(6'h20, 8'hC3, "t6_readback");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
